// File: rtl/video_pkg.sv
// Shared video types and colour defaults for the layer mixer.
package video_pkg;

  localparam int PKG_COLOR_W = 12;

  typedef logic [PKG_COLOR_W-1:0] rgb_t;

  localparam rgb_t KEY_COLOR_DEFAULT = 12'hF0F;
  localparam rgb_t BG_COLOR_DEFAULT  = 12'h000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_nib_t;

  function automatic rgb_nib_t rgb_split(input rgb_t c);
    rgb_nib_t s;
    s.r = c[11:8];
    s.g = c[7:4];
    s.b = c[3:0];
    return s;
  endfunction

endpackage

// File: rtl/layer_priority_select.sv
// Priority compositor stage: highest enabled opaque layer wins,
// or one forced layer, unkeyed, while the debug override is active.
module layer_priority_select
  import video_pkg::*;
#(
  parameter int                 NUM_LAYERS = 4,
  parameter int                 COLOR_W    = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR  = KEY_COLOR_DEFAULT,
  parameter logic [COLOR_W-1:0] BG_COLOR   = BG_COLOR_DEFAULT,
  localparam int SW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb_i,
  input  logic [NUM_LAYERS-1:0]         en_i,
  input  logic                          ovr_i,
  input  logic [SW-1:0]                 sel_i,
  output logic [COLOR_W-1:0]            pix_o
);

  logic [COLOR_W-1:0] pix_d;
  logic [COLOR_W-1:0] pix_q;

  // Ascending scan: later (higher-index) hits overwrite lower ones.
  always_comb begin
    pix_d = BG_COLOR;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (ovr_i) begin
        if (sel_i == SW'(i)) begin
          pix_d = layer_rgb_i[i*COLOR_W +: COLOR_W];
        end
      end else if (en_i[i] &&
                   layer_rgb_i[i*COLOR_W +: COLOR_W] != KEY_COLOR) begin
        pix_d = layer_rgb_i[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/video_layer_mixer.sv
// Layer compositor at the end of the VGA path: frame-shadowed enables,
// colour-keyed priority mix, flash overlay, delay-matched syncs.
module video_layer_mixer
  import video_pkg::*;
#(
  parameter int                 NUM_LAYERS   = 4,
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR    = KEY_COLOR_DEFAULT,
  parameter logic [COLOR_W-1:0] BG_COLOR     = BG_COLOR_DEFAULT,
  parameter int                 FLASH_FRAMES = 8,
  localparam int SW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int CW = COLOR_W / 3
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blank_in,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb_in,
  input  logic [NUM_LAYERS-1:0]         layer_en_in,
  input  logic                          dbg_sel_valid_in,
  input  logic [SW-1:0]                 dbg_sel_in,
  input  logic                          flash_trig_in,
  input  logic [COLOR_W-1:0]            flash_color_in,
  output logic [CW-1:0]                 vga_r,
  output logic [CW-1:0]                 vga_g,
  output logic [CW-1:0]                 vga_b,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          frame_start_out,
  output logic                          flash_active_out
);

  // S1
  logic                          hs1_q, vs1_q, bl1_q;
  logic [NUM_LAYERS*COLOR_W-1:0] rgb1_q;
  logic [COLOR_W-1:0]            fc1_q;
  logic                          fs_q;

  // active (shadowed) controls
  logic [NUM_LAYERS-1:0] en_q;
  logic                  ovr_q;
  logic [SW-1:0]         sel_q;
  logic                  sel_ok;

  // flash
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;

  // S2
  logic               hs2_q, vs2_q, bl2_q;
  logic [COLOR_W-1:0] fc2_q;
  logic [COLOR_W-1:0] pix2;

  // S3
  logic               hs3_q, vs3_q;
  logic [COLOR_W-1:0] rgb3_q, rgb3_d;

  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (dbg_sel_in == SW'(i)) begin
        sel_ok = 1'b1;
      end
    end
  end

  // A trigger landing on the load boundary re-arms for the next one.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q | flash_trig_in;
    if (fs_q) begin
      if (armed_q) begin
        cnt_d   = 8'(FLASH_FRAMES);
        armed_d = flash_trig_in;
      end else if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    rgb3_d = pix2;
    if (cnt_q[0]) begin
      rgb3_d = fc2_q;
    end
    if (bl2_q) begin
      rgb3_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      bl1_q   <= 1'b0;
      rgb1_q  <= '0;
      fc1_q   <= '0;
      fs_q    <= 1'b0;
      en_q    <= '0;
      ovr_q   <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= 8'd0;
      armed_q <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      bl2_q   <= 1'b0;
      fc2_q   <= '0;
      hs3_q   <= 1'b1;
      vs3_q   <= 1'b1;
      rgb3_q  <= '0;
    end else begin
      hs1_q   <= hsync_in;
      vs1_q   <= vsync_in;
      bl1_q   <= blank_in;
      rgb1_q  <= layer_rgb_in;
      fc1_q   <= flash_color_in;
      fs_q    <= vsync_in & ~vs1_q;
      if (fs_q) begin
        en_q  <= layer_en_in;
        ovr_q <= dbg_sel_valid_in & sel_ok;
        sel_q <= dbg_sel_in;
      end
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      bl2_q   <= bl1_q;
      fc2_q   <= fc1_q;
      hs3_q   <= ~hs2_q;
      vs3_q   <= ~vs2_q;
      rgb3_q  <= rgb3_d;
    end
  end

  layer_priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W),
    .KEY_COLOR  (KEY_COLOR),
    .BG_COLOR   (BG_COLOR)
  ) u_prio (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .layer_rgb_i (rgb1_q),
    .en_i        (en_q),
    .ovr_i       (ovr_q),
    .sel_i       (sel_q),
    .pix_o       (pix2)
  );

  assign vga_r            = rgb3_q[COLOR_W-1 -: CW];
  assign vga_g            = rgb3_q[2*CW-1 -: CW];
  assign vga_b            = rgb3_q[CW-1:0];
  assign vga_hs           = hs3_q;
  assign vga_vs           = vs3_q;
  assign frame_start_out  = fs_q;
  assign flash_active_out = (cnt_q != 8'd0);

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed bench for video_layer_mixer: latency, keying, shadowing,
// flash sequencing and mid-frame reset.
module tb_video_layer_mixer;
  import video_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        blank_in = 1'b0;
  logic [47:0] layer_rgb_in = '0;
  logic [3:0]  layer_en_in = '0;
  logic        dbg_sel_valid_in = 1'b0;
  logic [1:0]  dbg_sel_in = '0;
  logic        flash_trig_in = 1'b0;
  logic [11:0] flash_color_in = 12'hE00;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;
  logic        frame_start_out, flash_active_out;

  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  video_layer_mixer #(
    .NUM_LAYERS   (4),
    .COLOR_W      (12),
    .KEY_COLOR    (12'hF0F),
    .BG_COLOR     (12'h000),
    .FLASH_FRAMES (4)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .hsync_in         (hsync_in),
    .vsync_in         (vsync_in),
    .blank_in         (blank_in),
    .layer_rgb_in     (layer_rgb_in),
    .layer_en_in      (layer_en_in),
    .dbg_sel_valid_in (dbg_sel_valid_in),
    .dbg_sel_in       (dbg_sel_in),
    .flash_trig_in    (flash_trig_in),
    .flash_color_in   (flash_color_in),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .vga_hs           (vga_hs),
    .vga_vs           (vga_vs),
    .frame_start_out  (frame_start_out),
    .flash_active_out (flash_active_out)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input logic [11:0] exp);
    rgb_nib_t s;
    s = rgb_split(exp);
    chk(tag, {20'd0, vga_r, vga_g, vga_b}, {20'd0, s.r, s.g, s.b});
  endtask

  task automatic settle_pix(input string tag, input logic [11:0] exp);
    tick(3);
    chk_pix(tag, exp);
  endtask

  task automatic set_layers(input logic [11:0] l3, input logic [11:0] l2,
                            input logic [11:0] l1, input logic [11:0] l0);
    layer_rgb_in = {l3, l2, l1, l0};
  endtask

  // Vertical sync pulse; optional trigger in the boundary cycle.
  task automatic frame(input bit trig_at_fb = 1'b0);
    blank_in = 1'b1;
    vsync_in = 1'b1;
    tick();
    flash_trig_in = trig_at_fb;
    tick();
    flash_trig_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    blank_in = 1'b0;
  endtask

  task automatic pulse_trig();
    flash_trig_in = 1'b1;
    tick();
    flash_trig_in = 1'b0;
  endtask

  initial begin
    logic [7:0] cseq [5];
    logic [7:0] rseq [4];
    cseq = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    rseq = '{8'd3, 8'd2, 8'd1, 8'd0};

    #1 rst_n = 1'b0;
    #2;
    chk_pix("reset_rgb", 12'h000);
    chk("reset_hs", vga_hs, 1);
    chk("reset_vs", vga_vs, 1);
    chk("reset_fs", frame_start_out, 0);
    chk("reset_flash", flash_active_out, 0);
    tick(2);
    rst_n = 1'b1;

    set_layers(12'h123, 12'h456, 12'h789, 12'hABC);
    layer_en_in = 4'b1111;
    settle_pix("pre_fb_bg", 12'h000);

    blank_in = 1'b1;
    vsync_in = 1'b1;
    tick();
    chk("fs_pulse", frame_start_out, 1);
    tick();
    chk("fs_one_cycle", frame_start_out, 0);
    vsync_in = 1'b0;
    tick();
    blank_in = 1'b0;
    settle_pix("en_all_top", 12'h123);

    set_layers(12'h321, 12'h456, 12'h789, 12'hABC);
    tick();
    settle_pix("lat_steady", 12'h321);
    set_layers(12'h123, 12'h456, 12'h789, 12'hABC);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    tick();
    set_layers(12'h321, 12'h456, 12'h789, 12'hABC);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    chk_pix("lat_2clk_rgb", 12'h321);
    chk("lat_2clk_hs", vga_hs, 1);
    tick();
    chk_pix("lat_3clk_rgb", 12'h123);
    chk("lat_3clk_hs", vga_hs, 0);
    chk("lat_3clk_vs", vga_vs, 0);
    tick();
    chk_pix("lat_4clk_rgb", 12'h321);
    chk("lat_4clk_hs", vga_hs, 1);

    set_layers(12'hF0F, 12'h0A0, 12'h00F, 12'hABC);
    settle_pix("key_l3", 12'h0A0);
    layer_en_in = 4'b1011;
    settle_pix("key_en_hold", 12'h0A0);
    frame();
    settle_pix("key_l2_off", 12'h00F);
    set_layers(12'hF0F, 12'h0A0, 12'hF0F, 12'hF0F);
    settle_pix("key_all_bg", 12'h000);

    set_layers(12'hF0F, 12'h0A0, 12'h00F, 12'hABC);
    layer_en_in = 4'b1111;
    frame();
    settle_pix("shd_base", 12'h0A0);
    layer_en_in = 4'b0001;
    settle_pix("shd_mid", 12'h0A0);
    frame();
    settle_pix("shd_after_fb", 12'hABC);
    dbg_sel_valid_in = 1'b1;
    dbg_sel_in = 2'd3;
    settle_pix("ovr_mid", 12'hABC);
    frame();
    settle_pix("ovr_raw", 12'hF0F);
    dbg_sel_valid_in = 1'b0;
    frame();
    settle_pix("ovr_off", 12'hABC);

    blank_in = 1'b1;
    settle_pix("blanked", 12'h000);
    blank_in = 1'b0;
    settle_pix("unblanked", 12'hABC);

    pulse_trig();
    tick(3);
    chk("flash_armed_idle", flash_active_out, 0);
    chk_pix("flash_armed_pix", 12'hABC);
    for (int k = 0; k < 5; k++) begin
      frame();
      tick(3);
      chk($sformatf("flash_act_%0d", cseq[k]), flash_active_out,
          {31'd0, cseq[k] != 8'd0});
      chk_pix($sformatf("flash_pix_%0d", cseq[k]),
              cseq[k][0] ? 12'hE00 : 12'hABC);
    end

    frame(1'b1);
    tick(3);
    chk("coinc_no_load", flash_active_out, 0);
    frame();
    tick(3);
    chk("coinc_load_act", flash_active_out, 1);
    chk_pix("coinc_load_pix", 12'hABC);
    frame();
    settle_pix("coinc_c3", 12'hE00);
    frame();
    settle_pix("coinc_c2", 12'hABC);
    pulse_trig();
    frame();
    tick(3);
    chk("reload_act", flash_active_out, 1);
    chk_pix("reload_pix", 12'hABC);
    for (int k = 0; k < 4; k++) begin
      frame();
      tick(3);
      chk($sformatf("reload_act_%0d", rseq[k]), flash_active_out,
          {31'd0, rseq[k] != 8'd0});
      chk_pix($sformatf("reload_pix_%0d", rseq[k]),
              rseq[k][0] ? 12'hE00 : 12'hABC);
    end

    pulse_trig();
    frame();
    hsync_in = 1'b1;
    tick(3);
    chk("prerst_flash", flash_active_out, 1);
    chk("prerst_hs", vga_hs, 0);
    chk_pix("prerst_pix", 12'hABC);
    rst_n = 1'b0;
    #2;
    chk_pix("rst_mid_rgb", 12'h000);
    chk("rst_mid_hs", vga_hs, 1);
    chk("rst_mid_vs", vga_vs, 1);
    chk("rst_mid_flash", flash_active_out, 0);
    tick(5);
    rst_n = 1'b1;
    hsync_in = 1'b0;
    settle_pix("post_rst_bg", 12'h000);
    chk("post_rst_flash", flash_active_out, 0);
    frame();
    settle_pix("post_rst_fb", 12'hABC);
    chk("post_rst_fb_flash", flash_active_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
